find_max_job_arbiter: RTL and testbench

- Shares one find_max engine (`x_out` value stream out, `return_in` result back) between N requesters.
- Each requester submits a job of exactly LEN 32-bit values.
- The arbiter grants one job at a time in round-robin order and streams its values to the engine. It then captures the engine's result and returns it to the owning requester.
- Sits between the requester blocks and the `dut` engine ports in the hierarchy.

---
 rtl/find_max_job_arbiter.sv | 168 ++++++++++++++++
 tb/tb_find_max_job_arbiter.sv | 515 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/find_max_job_arbiter.sv
// Round-robin arbiter sharing one find_max engine between N requesters.
// Each granted job streams LEN values out and returns the engine's result.
module find_max_job_arbiter #(
  parameter int N   = 4,
  parameter int LEN = 8,
  parameter int DW  = 32,
  parameter int IDW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req_x_in_vld,
  input  logic [N*DW-1:0] req_x_in_data,
  output logic [N-1:0]    req_x_in_busy,
  output logic            eng_x_out_vld,
  output logic [DW-1:0]   eng_x_out_data,
  input  logic            eng_x_out_busy,
  input  logic            eng_return_in_vld,
  input  logic [DW-1:0]   eng_return_in_data,
  output logic            eng_return_in_busy,
  output logic [N-1:0]    rsp_out_vld,
  output logic [DW-1:0]   rsp_out_data,
  input  logic [N-1:0]    rsp_out_busy,
  output logic [IDW-1:0]  grant_id,
  output logic            active,
  output logic [15:0]     jobs_done
);

  localparam int CW = $clog2(LEN);
  localparam int SW = IDW + 1;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    WAIT_RES,
    RESP
  } state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] grant_q, grant_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           active_q, active_d;
  logic [15:0]    done_q, done_d;
  logic [DW-1:0]  rsp_q, rsp_d;

  logic [DW-1:0]  req_data [N];
  logic [SW-1:0]  scan_idx;
  logic           win_found;
  logic [IDW-1:0] win_id;
  logic           eng_xfer;
  logic           ret_xfer;
  logic           rsp_xfer;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_data[i] = req_x_in_data[i*DW +: DW];
    end
  end

  // Lowest offset from rr_ptr wins, so scan from the far end down.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    scan_idx  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      scan_idx = {1'b0, rr_ptr_q} + SW'(i);
      if (scan_idx >= SW'(N)) begin
        scan_idx = scan_idx - SW'(N);
      end
      if (req_x_in_vld[scan_idx[IDW-1:0]]) begin
        win_found = 1'b1;
        win_id    = scan_idx[IDW-1:0];
      end
    end
  end

  always_comb begin
    req_x_in_busy      = '1;
    eng_x_out_vld      = 1'b0;
    eng_x_out_data     = req_data[grant_q];
    eng_return_in_busy = 1'b1;
    rsp_out_vld        = '0;
    unique case (state_q)
      STREAM: begin
        eng_x_out_vld          = req_x_in_vld[grant_q];
        req_x_in_busy[grant_q] = eng_x_out_busy;
      end
      WAIT_RES: eng_return_in_busy = 1'b0;
      RESP:     rsp_out_vld[grant_q] = 1'b1;
      default: ;
    endcase
  end

  assign eng_xfer = eng_x_out_vld && !eng_x_out_busy;
  assign ret_xfer = (state_q == WAIT_RES) && eng_return_in_vld;
  assign rsp_xfer = (state_q == RESP) && !rsp_out_busy[grant_q];

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    done_d   = done_q;
    rsp_d    = rsp_q;
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          grant_d  = win_id;
          cnt_d    = '0;
          active_d = 1'b1;
          state_d  = STREAM;
        end
      end
      STREAM: begin
        if (eng_xfer) begin
          if (cnt_q == CW'(LEN - 1)) begin
            cnt_d   = '0;
            state_d = WAIT_RES;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      WAIT_RES: begin
        if (ret_xfer) begin
          rsp_d   = eng_return_in_data;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_xfer) begin
          done_d   = done_q + 16'd1;
          rr_ptr_d = (grant_q == IDW'(N - 1)) ? '0 : grant_q + 1'b1;
          active_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
      done_q   <= '0;
      rsp_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
      done_q   <= done_d;
      rsp_q    <= rsp_d;
    end
  end

  assign grant_id     = grant_q;
  assign active       = active_q;
  assign jobs_done    = done_q;
  assign rsp_out_data = rsp_q;

endmodule

// File: tb/tb_find_max_job_arbiter.sv
// Bench for find_max_job_arbiter: requester/engine models plus
// per-scenario checks against a round-robin reference.
module tb_find_max_job_arbiter;

  localparam int N   = 4;
  localparam int LEN = 4;
  localparam int DW  = 32;
  localparam int IDW = 2;

  typedef struct packed {
    logic [7:0]          id;
    logic [LEN*DW-1:0]   vals;
  } job_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_vld;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_busy;
  logic            eng_vld;
  logic [DW-1:0]   eng_data;
  logic            eng_busy;
  logic            ret_vld;
  logic [DW-1:0]   ret_data;
  logic            ret_busy;
  logic [N-1:0]    rsp_vld;
  logic [DW-1:0]   rsp_data;
  logic [N-1:0]    rsp_busy;
  logic [IDW-1:0]  grant_id;
  logic            active;
  logic [15:0]     jobs_done;

  always #5 clk = ~clk;

  find_max_job_arbiter #(
    .N(N), .LEN(LEN), .DW(DW), .IDW(IDW)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .req_x_in_vld       (req_vld),
    .req_x_in_data      (req_data),
    .req_x_in_busy      (req_busy),
    .eng_x_out_vld      (eng_vld),
    .eng_x_out_data     (eng_data),
    .eng_x_out_busy     (eng_busy),
    .eng_return_in_vld  (ret_vld),
    .eng_return_in_data (ret_data),
    .eng_return_in_busy (ret_busy),
    .rsp_out_vld        (rsp_vld),
    .rsp_out_data       (rsp_data),
    .rsp_out_busy       (rsp_busy),
    .grant_id           (grant_id),
    .active             (active),
    .jobs_done          (jobs_done)
  );

  int vec = 0;
  int mis = 0;
  int cyc = 0;

  logic [DW-1:0] rq_buf [N][64];
  int            rq_head [N];
  int            rq_tail [N];
  job_t          jobs_q [$];

  logic [DW-1:0] eng_seen [$];
  int            eng_own [$];
  int            eng_cyc [$];
  int            rsp_id [$];
  logic [DW-1:0] rsp_val [$];
  int            ret_cnt;

  int            eng_stall_pct;
  int            rsp_stall_pct;
  bit            eng_busy_frc;
  logic [N-1:0]  rsp_busy_frc;
  bit            eng_auto;
  int            e_cnt;
  logic [DW-1:0] e_max;

  function automatic logic [DW-1:0] job_max(logic [LEN*DW-1:0] v);
    logic [DW-1:0] m;
    m = v[DW-1:0];
    for (int k = 1; k < LEN; k++) begin
      if (v[k*DW +: DW] > m) m = v[k*DW +: DW];
    end
    return m;
  endfunction

  function automatic logic [LEN*DW-1:0] nth_job(int r, int m);
    int seen;
    seen = 0;
    for (int j = 0; j < jobs_q.size(); j++) begin
      if (int'(jobs_q[j].id) == r) begin
        if (seen == m) return jobs_q[j].vals;
        seen++;
      end
    end
    return '0;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (rq_head[i] != rq_tail[i]) begin
        req_vld[i] = 1'b1;
        req_data[i*DW +: DW] = rq_buf[i][rq_head[i]];
      end else begin
        req_vld[i] = 1'b0;
        req_data[i*DW +: DW] = '0;
      end
      rsp_busy[i] = rsp_busy_frc[i] ||
                    ($urandom_range(0, 99) < rsp_stall_pct);
    end
    eng_busy = eng_busy_frc ||
               ($urandom_range(0, 99) < eng_stall_pct);
  endtask

  task automatic push_job(int r, logic [LEN*DW-1:0] v);
    job_t j;
    for (int k = 0; k < LEN; k++) begin
      rq_buf[r][rq_tail[r]] = v[k*DW +: DW];
      rq_tail[r]++;
    end
    j.id   = 8'(r);
    j.vals = v;
    jobs_q.push_back(j);
    drive();
  endtask

  function automatic logic [LEN*DW-1:0] rand_vals();
    logic [LEN*DW-1:0] v;
    for (int k = 0; k < LEN; k++) v[k*DW +: DW] = $urandom();
    return v;
  endfunction

  // One clock: record transfers seen before the edge, then let the
  // requester and engine models react.
  task automatic step();
    logic [N-1:0] rx;
    logic ex;
    logic tx;
    #1;
    rx = req_vld & ~req_busy;
    ex = eng_vld && !eng_busy;
    tx = ret_vld && !ret_busy;
    if (ex) begin
      eng_seen.push_back(eng_data);
      eng_own.push_back(int'(grant_id));
      eng_cyc.push_back(cyc);
    end
    for (int i = 0; i < N; i++) begin
      if (rsp_vld[i] && !rsp_busy[i]) begin
        rsp_id.push_back(i);
        rsp_val.push_back(rsp_data);
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    for (int i = 0; i < N; i++) if (rx[i]) rq_head[i]++;
    if (tx) begin
      ret_vld = 1'b0;
      ret_cnt++;
    end
    if (ex) begin
      if (e_cnt == 0 || eng_data > e_max) e_max = eng_data;
      e_cnt++;
      if (e_cnt == LEN) begin
        e_cnt = 0;
        if (eng_auto) begin
          ret_vld  = 1'b1;
          ret_data = e_max;
        end
      end
    end
    drive();
    #1;
  endtask

  task automatic run_until_rsp(int n, int budget, output bit ok);
    while (rsp_id.size() < n && budget > 0) begin
      step();
      budget--;
    end
    ok = (rsp_id.size() >= n);
  endtask

  task automatic run_until_seen(int n, int budget, output bit ok);
    while (eng_seen.size() < n && budget > 0) begin
      step();
      budget--;
    end
    ok = (eng_seen.size() >= n);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      rq_head[i] = 0;
      rq_tail[i] = 0;
    end
    jobs_q.delete();
    eng_seen.delete();
    eng_own.delete();
    eng_cyc.delete();
    rsp_id.delete();
    rsp_val.delete();
    ret_vld = 1'b0;
    ret_data = '0;
    ret_cnt = 0;
    e_cnt = 0;
    e_max = '0;
    eng_stall_pct = 0;
    rsp_stall_pct = 0;
    eng_busy_frc = 1'b0;
    rsp_busy_frc = '0;
    eng_auto = 1'b1;
    drive();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req_vld = '1;
    req_data = {N{32'hdead_beef}};
    eng_busy = 1'b0;
    ret_vld = 1'b1;
    ret_data = 32'h1234;
    rsp_busy = '0;
    repeat (2) @(posedge clk);
    #1;
    vec++; if (req_busy !== '1) begin mis++;
      $display("FAIL rst_req_busy: got %b want 1111", req_busy); end
    vec++; if (eng_vld !== 1'b0) begin mis++;
      $display("FAIL rst_eng_vld: got %b want 0", eng_vld); end
    vec++; if (ret_busy !== 1'b1) begin mis++;
      $display("FAIL rst_ret_busy: got %b want 1", ret_busy); end
    vec++; if (rsp_vld !== '0) begin mis++;
      $display("FAIL rst_rsp_vld: got %b want 0000", rsp_vld); end
    vec++; if (rsp_data !== '0) begin mis++;
      $display("FAIL rst_rsp_data: got %0h want 0", rsp_data); end
    vec++; if (grant_id !== '0) begin mis++;
      $display("FAIL rst_grant: got %0d want 0", grant_id); end
    vec++; if (active !== 1'b0) begin mis++;
      $display("FAIL rst_active: got %b want 0", active); end
    vec++; if (jobs_done !== 16'd0) begin mis++;
      $display("FAIL rst_jobs_done: got %0d want 0", jobs_done); end
  endtask

  task automatic test_basic();
    logic [LEN*DW-1:0] v;
    bit ok;
    do_reset();
    v = {32'd7, 32'd2, 32'd9, 32'd3};
    push_job(0, v);
    run_until_rsp(1, 40, ok);
    vec++; if (!ok) begin mis++;
      $display("FAIL basic_done: got %0d rsp want 1", rsp_id.size()); end
    vec++; if (eng_seen.size() != LEN) begin mis++;
      $display("FAIL basic_len: got %0d want %0d", eng_seen.size(), LEN); end
    for (int k = 0; k < LEN && k < eng_seen.size(); k++) begin
      vec++; if (eng_seen[k] !== v[k*DW +: DW]) begin mis++;
        $display("FAIL basic_val%0d: got %0d want %0d",
                 k, eng_seen[k], v[k*DW +: DW]); end
      vec++; if (eng_own[k] != 0) begin mis++;
        $display("FAIL basic_own%0d: got %0d want 0", k, eng_own[k]); end
    end
    if (eng_cyc.size() == LEN) begin
      vec++; if (eng_cyc[LEN-1] - eng_cyc[0] != LEN - 1) begin mis++;
        $display("FAIL basic_consec: got span %0d want %0d",
                 eng_cyc[LEN-1] - eng_cyc[0], LEN - 1); end
    end
    if (ok) begin
      vec++; if (rsp_id[0] != 0 || rsp_val[0] !== 32'd9) begin mis++;
        $display("FAIL basic_rsp: got id %0d data %0d want id 0 data 9",
                 rsp_id[0], rsp_val[0]); end
    end
    vec++; if (jobs_done !== 16'd1 || active !== 1'b0) begin mis++;
      $display("FAIL basic_done_cnt: got %0d/%b want 1/0",
               jobs_done, active); end
    step();
    step();
    vec++; if (rsp_data !== 32'd9) begin mis++;
      $display("FAIL basic_hold: got %0d want 9", rsp_data); end
  endtask

  task automatic test_round_robin();
    logic [LEN*DW-1:0] a, b, c, d;
    int exp_id [4];
    logic [DW-1:0] exp_v [4];
    bit ok;
    do_reset();
    push_job(0, rand_vals());
    push_job(2, rand_vals());
    run_until_rsp(2, 60, ok);
    vec++; if (!ok || rsp_id[0] != 0 || rsp_id[1] != 2) begin mis++;
      $display("FAIL rr_pair: got %0d rsps want order 0,2",
               rsp_id.size()); end

    do_reset();
    a = rand_vals(); b = rand_vals();
    c = rand_vals(); d = rand_vals();
    push_job(0, a);
    push_job(2, b);
    run_until_seen(LEN, 30, ok);
    push_job(1, c);
    push_job(0, d);
    run_until_rsp(4, 120, ok);
    exp_id = '{0, 1, 2, 0};
    exp_v[0] = job_max(a); exp_v[1] = job_max(c);
    exp_v[2] = job_max(b); exp_v[3] = job_max(d);
    vec++; if (!ok) begin mis++;
      $display("FAIL rr_count: got %0d want 4", rsp_id.size()); end
    for (int j = 0; j < 4 && j < rsp_id.size(); j++) begin
      vec++;
      if (rsp_id[j] != exp_id[j] || rsp_val[j] !== exp_v[j]) begin mis++;
        $display("FAIL rr_job%0d: got id %0d %0h want id %0d %0h",
                 j, rsp_id[j], rsp_val[j], exp_id[j], exp_v[j]); end
    end
  endtask

  task automatic test_eng_stall();
    logic [LEN*DW-1:0] v;
    bit ok;
    do_reset();
    v = rand_vals();
    push_job(3, v);
    run_until_seen(2, 20, ok);
    eng_busy_frc = 1'b1;
    eng_busy = 1'b1;
    for (int s = 0; s < 3; s++) begin
      #1;
      vec++; if (req_busy[3] !== 1'b1 || eng_vld !== 1'b1) begin mis++;
        $display("FAIL stall_busy%0d: got %b/%b want 1/1",
                 s, req_busy[3], eng_vld); end
      if (s == 2) eng_busy_frc = 1'b0;
      step();
      vec++; if (eng_seen.size() != 2) begin mis++;
        $display("FAIL stall_hold%0d: got %0d want 2",
                 s, eng_seen.size()); end
    end
    vec++; if (req_busy[3] !== 1'b0) begin mis++;
      $display("FAIL stall_release: got %b want 0", req_busy[3]); end
    run_until_rsp(1, 30, ok);
    vec++; if (eng_seen.size() != LEN) begin mis++;
      $display("FAIL stall_len: got %0d want %0d", eng_seen.size(), LEN); end
    for (int k = 0; k < LEN && k < eng_seen.size(); k++) begin
      vec++; if (eng_seen[k] !== v[k*DW +: DW]) begin mis++;
        $display("FAIL stall_val%0d: got %0h want %0h",
                 k, eng_seen[k], v[k*DW +: DW]); end
    end
    vec++; if (!ok || rsp_val[0] !== job_max(v)) begin mis++;
      $display("FAIL stall_rsp: got %0d rsps want max %0h",
               rsp_id.size(), job_max(v)); end
  endtask

  task automatic test_early_result();
    bit ok;
    int budget;
    do_reset();
    eng_auto = 1'b0;
    push_job(1, rand_vals());
    run_until_seen(1, 20, ok);
    ret_vld = 1'b1;
    ret_data = 32'h55;
    budget = 30;
    while (eng_seen.size() < LEN && budget > 0) begin
      #1;
      vec++; if (ret_busy !== 1'b1) begin mis++;
        $display("FAIL early_busy: got %b want 1 at %0d values",
                 ret_busy, eng_seen.size()); end
      step();
      budget--;
    end
    #1;
    vec++; if (ret_busy !== 1'b0) begin mis++;
      $display("FAIL early_wait: got %b want 0", ret_busy); end
    run_until_rsp(1, 20, ok);
    vec++; if (ret_cnt != 1) begin mis++;
      $display("FAIL early_once: got %0d want 1", ret_cnt); end
    vec++; if (!ok || rsp_val[0] !== 32'h55 || rsp_id[0] != 1) begin mis++;
      $display("FAIL early_rsp: got %0d rsps %0h want 55 to req1",
               rsp_id.size(), rsp_data); end
  endtask

  task automatic test_rsp_stall();
    logic [LEN*DW-1:0] v;
    bit ok;
    int budget;
    do_reset();
    rsp_busy_frc = '1;
    v = rand_vals();
    push_job(2, v);
    budget = 30;
    while (rsp_vld == '0 && budget > 0) begin
      step();
      budget--;
    end
    push_job(0, rand_vals());
    for (int s = 0; s < 5; s++) begin
      #1;
      vec++;
      if (rsp_vld !== 4'b0100 || rsp_data !== job_max(v) ||
          jobs_done !== 16'd0 || grant_id !== 2'd2 ||
          active !== 1'b1 || eng_vld !== 1'b0) begin mis++;
        $display("FAIL rsp_stall%0d: got vld %b data %0h done %0d gnt %0d want 0100 %0h 0 2",
                 s, rsp_vld, rsp_data, jobs_done, grant_id, job_max(v)); end
      step();
    end
    rsp_busy_frc = '0;
    drive();
    run_until_rsp(1, 5, ok);
    vec++; if (!ok || rsp_id[0] != 2 || jobs_done !== 16'd1) begin mis++;
      $display("FAIL rsp_release: got %0d rsps done %0d want 1 1",
               rsp_id.size(), jobs_done); end
    run_until_rsp(2, 40, ok);
    vec++; if (!ok || rsp_id[1] != 0) begin mis++;
      $display("FAIL rsp_next: got %0d rsps want req0 second",
               rsp_id.size()); end
  endtask

  task automatic test_reset_mid();
    logic [LEN*DW-1:0] v;
    bit ok;
    do_reset();
    push_job(2, rand_vals());
    run_until_rsp(1, 30, ok);
    push_job(2, rand_vals());
    run_until_seen(LEN + 2, 30, ok);
    rst = 1'b0;
    #1;
    vec++;
    if (req_busy !== '1 || eng_vld !== 1'b0 || ret_busy !== 1'b1 ||
        rsp_vld !== '0 || rsp_data !== '0 || grant_id !== '0 ||
        active !== 1'b0 || jobs_done !== 16'd0) begin mis++;
      $display("FAIL mid_reset: got busy %b ev %b rb %b rv %b rd %0h g %0d a %b d %0d want all reset",
               req_busy, eng_vld, ret_busy, rsp_vld, rsp_data,
               grant_id, active, jobs_done); end
    do_reset();
    v = rand_vals();
    push_job(1, v);
    run_until_rsp(1, 30, ok);
    vec++;
    if (!ok || rsp_id[0] != 1 || rsp_val[0] !== job_max(v) ||
        jobs_done !== 16'd1) begin mis++;
      $display("FAIL mid_fresh: got %0d rsps done %0d want 1 job of req1",
               rsp_id.size(), jobs_done); end
  endtask

  task automatic test_random();
    int cnt [N];
    int used [N];
    int order [$];
    logic [DW-1:0] exp_seen [$];
    logic [LEN*DW-1:0] v;
    int rr, total, r;
    bit ok;
    do_reset();
    eng_stall_pct = 30;
    rsp_stall_pct = 30;
    total = 0;
    for (int i = 0; i < N; i++) begin
      cnt[i] = $urandom_range(1, 3);
      used[i] = 0;
      for (int m = 0; m < cnt[i]; m++) push_job(i, rand_vals());
      total += cnt[i];
    end
    rr = 0;
    for (int j = 0; j < total; j++) begin
      for (int k = 0; k < N; k++) begin
        r = (rr + k) % N;
        if (cnt[r] > 0) begin
          cnt[r]--;
          order.push_back(r);
          rr = (r + 1) % N;
          break;
        end
      end
    end
    run_until_rsp(total, 1500, ok);
    vec++; if (!ok) begin mis++;
      $display("FAIL rand_count: got %0d want %0d", rsp_id.size(), total); end
    for (int j = 0; j < total && j < rsp_id.size(); j++) begin
      r = order[j];
      v = nth_job(r, used[r]);
      used[r]++;
      for (int k = 0; k < LEN; k++) exp_seen.push_back(v[k*DW +: DW]);
      vec++;
      if (rsp_id[j] != r || rsp_val[j] !== job_max(v)) begin mis++;
        $display("FAIL rand_job%0d: got id %0d %0h want id %0d %0h",
                 j, rsp_id[j], rsp_val[j], r, job_max(v)); end
    end
    for (int k = 0; k < exp_seen.size() && k < eng_seen.size(); k++) begin
      vec++; if (eng_seen[k] !== exp_seen[k]) begin mis++;
        $display("FAIL rand_val%0d: got %0h want %0h",
                 k, eng_seen[k], exp_seen[k]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_eng_stall();
    test_early_result();
    test_rsp_stall();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end

endmodule
